// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-path control.
// Revision: 1.0
`default_nettype none

package router_pkg;

  localparam int NUM_CH = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/router_fsm_ctrl.sv
// Packet-level control FSM: header decode, payload/parity load sequencing, FIFO-full stall.
// Revision: 1.0
`default_nettype none

module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  state_t     state;
  logic [1:0] addr_q;

  // Padding to four entries lets the invalid address index a defined 0.
  logic [3:0] empty_ext;
  logic [3:0] soft_ext;
  logic       hdr_valid;
  logic       soft_hit;

  assign empty_ext = {1'b0, fifo_empty};
  assign soft_ext  = {1'b0, soft_reset};
  assign hdr_valid = pkt_valid && (data_in != ADDR_INVALID);
  assign soft_hit  = soft_ext[addr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= 2'b00;
    end else begin
      if (state == DECODE_ADDRESS && hdr_valid)
        addr_q <= data_in;

      if (state != DECODE_ADDRESS && soft_hit) begin
        state <= DECODE_ADDRESS;
      end else begin
        case (state)
          DECODE_ADDRESS: begin
            if (hdr_valid)
              state <= empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
          WAIT_TILL_EMPTY: begin
            if (empty_ext[addr_q])
              state <= LOAD_FIRST_DATA;
          end
          LOAD_FIRST_DATA: state <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)       state <= FIFO_FULL_STATE;
            else if (!pkt_valid) state <= LOAD_PARITY;
          end
          FIFO_FULL_STATE: begin
            if (!fifo_full) state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)        state <= DECODE_ADDRESS;
            else if (low_pkt_valid) state <= LOAD_PARITY;
            else                    state <= LOAD_DATA;
          end
          LOAD_PARITY: state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
          default: state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

`default_nettype wire

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
Packet-level control FSM for the 1x3 router input path. It sits directly upstream of the router's data register stage. It decodes the header address, sequences header, payload and parity loading, and stalls on FIFO full. It drives the stage strobes detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg and write_enb_reg, plus the source-facing busy, and consumes the stage's parity_done and low_pkt_valid.

Parameters:
None. Channel count is fixed at 3. Address value 2'b11 is invalid.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
pkt_valid  in  1  source packet-valid
data_in  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
fifo_full  in  1  full flag of the currently addressed FIFO (muxed externally)
fifo_empty  in  3  per-channel FIFO empty flags
soft_reset  in  3  per-channel soft resets (read-timeout)
parity_done  in  1  from register stage
low_pkt_valid  in  1  from register stage
detect_add  out  1  state==DECODE_ADDRESS
lfd_state  out  1  state==LOAD_FIRST_DATA
ld_state  out  1  state==LOAD_DATA
full_state  out  1  state==FIFO_FULL_STATE
laf_state  out  1  state==LOAD_AFTER_FULL
rst_int_reg  out  1  state==CHECK_PARITY_ERROR
write_enb_reg  out  1  FIFO write enable
busy  out  1  source must hold data_in

Behaviour:
- Moore machine. All outputs decode combinationally from the state register only, with no input-to-output path.
- Reset: reset==0 at a clk edge forces state=DECODE_ADDRESS and addr_q=2'b00.
  - Output values during reset: detect_add=1, all other outputs 0.
  - Reset mid-packet aborts the packet immediately.
- addr_q: loaded with data_in in DECODE_ADDRESS when pkt_valid==1 and data_in!=2'b11. Held otherwise.
- Transitions, evaluated each edge:
  - DECODE_ADDRESS:
    - pkt_valid==1, data_in==a (a in 0..2), fifo_empty[a]==1 -> LOAD_FIRST_DATA
    - pkt_valid==1, data_in==a, fifo_empty[a]==0 -> WAIT_TILL_EMPTY
    - data_in==2'b11 or pkt_valid==0 -> stay. The invalid packet is dropped.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q]==1 -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA: unconditionally -> LOAD_DATA.
  - LOAD_DATA:
    - fifo_full==1 -> FIFO_FULL_STATE
    - else pkt_valid==0 -> LOAD_PARITY
    - else stay
  - FIFO_FULL_STATE: fifo_full==0 -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done==1 -> DECODE_ADDRESS
    - else low_pkt_valid==1 -> LOAD_PARITY
    - else -> LOAD_DATA
  - LOAD_PARITY: unconditionally -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full==1 -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset: soft_reset[addr_q]==1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next edge. This has priority over all transitions except reset. soft_reset on other channels is ignored.
- write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL. Header write relies on lfd_state.
- busy=1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR. busy=0 in DECODE_ADDRESS and LOAD_DATA.
- Exactly one of detect_add/lfd_state/ld_state/full_state/laf_state/rst_int_reg is high in the six states that drive them. All six are low in WAIT_TILL_EMPTY and LOAD_PARITY.
- Latency: header accepted at edge N, lfd_state high in cycle N+1, ld_state from N+2.
- Illegal or unreachable state encodings recover to DECODE_ADDRESS on the next edge.

Decomposition:
- Shared package router_pkg holds:
  - state enum (8 states, 3-bit binary encoding)
  - ADDR_INVALID=2'b11
  - NUM_CH=3
- No sub-module. A single next-state block plus state/addr_q registers and an output decode is sufficient.

Test Plan:
- Reset low 2 cycles: detect_add=1, busy=0, others 0. Release with pkt_valid=0: state stays DECODE_ADDRESS.
- Packet to ch1 with fifo_empty=3'b111, header then 4 payload, pkt_valid drops:
  - states go DA->LFD->LD x4->LP->CPE->DA
  - write_enb_reg high 5 cycles
  - rst_int_reg high 1 cycle
- Header addr 2 with fifo_empty[2]=0 for 3 cycles:
  - WAIT_TILL_EMPTY held 3 cycles with busy=1
  - then LFD once fifo_empty[2]=1
- fifo_full=1 during LOAD_DATA for 2 cycles:
  - FIFO_FULL_STATE (full_state=1, busy=1, write_enb_reg=0)
  - LOAD_AFTER_FULL with parity_done=0, low_pkt_valid=1 -> LOAD_PARITY
  - repeat with parity_done=1 -> DECODE_ADDRESS
- Header data_in=2'b11 with pkt_valid=1: stays DECODE_ADDRESS, addr_q unchanged.
- soft_reset[0] pulse while in LOAD_DATA for ch0 -> DECODE_ADDRESS next edge. soft_reset[1] during a ch0 packet -> no effect.
